// File: rtl/wdt_supervisor.sv
// wdt_supervisor: collects per-client heartbeats, kicks an external watchdog
// once every client has checked in and the minimum window has elapsed, and
// escalates repeated watchdog timeouts into a held system reset.
// Optional build macro: WDT_SUPERVISOR_STATUS_EN exposes the missing-client
// mask and the strike counter on the status ports; without it they read 0.
module wdt_supervisor #(
  parameter int NCLIENT  = 4,
  parameter int WIN_OPEN = 10,
  parameter int STRIKES  = 2,
  parameter int HOLD     = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NCLIENT-1:0] checkin,
  input  logic               wd_timeout,
  output logic               wd_kick,
  output logic               wd_reset_n,
  output logic               alert,
  output logic               sys_rst,
  output logic [NCLIENT-1:0] missing,
  output logic [2:0]         strike_cnt
);

  // Window counter only needs to reach WIN_OPEN, where it saturates.
  localparam int WIN_W = (WIN_OPEN < 1) ? 1 : $clog2(WIN_OPEN + 1);
  localparam logic [WIN_W-1:0]   WIN_MAX    = WIN_W'(WIN_OPEN);
  localparam logic [7:0]         HOLD_LAST  = 8'(HOLD - 1);
  localparam logic [2:0]         STRIKE_LIM = 3'(STRIKES);
  localparam logic [NCLIENT-1:0] ALL_IN     = '1;

  typedef enum logic [2:0] {
    ST_COLLECT  = 3'd0,
    ST_WAIT_WIN = 3'd1,
    ST_KICK     = 3'd2,
    ST_ALERT    = 3'd3,
    ST_HOLD_RST = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [NCLIENT-1:0] mask_reg, mask_next;
  logic [NCLIENT-1:0] mask_merged;
  logic [WIN_W-1:0]   win_reg, win_next;
  logic [2:0]         strike_reg, strike_next;
  logic [7:0]         hold_reg, hold_next;
  logic               alert_reg, alert_next;
  logic               take_timeout;

  logic               wd_kick_reg;
  logic               wd_reset_n_reg;
  logic               sys_rst_reg;

  // Pending mask including this cycle's heartbeats, one sticky bit per client.
  for (genvar gi = 0; gi < NCLIENT; gi++) begin : g_client
    assign mask_merged[gi] = mask_reg[gi] | checkin[gi];
  end

  // Next-state logic; a watchdog timeout in the active states overrides all.
  always_comb begin
    state_next   = state_reg;
    mask_next    = mask_reg;
    win_next     = (win_reg >= WIN_MAX) ? WIN_MAX : win_reg + 1'b1;
    strike_next  = strike_reg;
    hold_next    = hold_reg;
    alert_next   = alert_reg;
    take_timeout = 1'b0;

    case (state_reg)
      ST_COLLECT: begin
        mask_next = mask_merged;
        if (wd_timeout) begin
          take_timeout = 1'b1;
        end else if (mask_merged == ALL_IN) begin
          state_next = ST_WAIT_WIN;
        end
      end
      ST_WAIT_WIN: begin
        mask_next = mask_merged;
        if (wd_timeout) begin
          take_timeout = 1'b1;
        end else if (win_reg >= WIN_MAX) begin
          state_next = ST_KICK;
        end
      end
      ST_KICK: begin
        // Heartbeats seen during the kick cycle seed the next round.
        win_next  = '0;
        mask_next = checkin;
        if (wd_timeout) begin
          take_timeout = 1'b1;
        end else begin
          state_next = ST_COLLECT;
        end
      end
      ST_ALERT: begin
        mask_next  = '0;
        win_next   = '0;
        hold_next  = '0;
        state_next = (strike_reg == STRIKE_LIM) ? ST_HOLD_RST : ST_COLLECT;
      end
      ST_HOLD_RST: begin
        if (hold_reg == HOLD_LAST) begin
          strike_next = '0;
          state_next  = ST_COLLECT;
        end else begin
          hold_next = hold_reg + 8'd1;
        end
      end
      default: begin
        state_next = ST_COLLECT;
        mask_next  = '0;
      end
    endcase

    if (take_timeout) begin
      state_next  = ST_ALERT;
      strike_next = strike_reg + 3'd1;
      alert_next  = 1'b1;
    end
  end

  // Core state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg  <= ST_COLLECT;
      mask_reg   <= '0;
      win_reg    <= '0;
      strike_reg <= '0;
      hold_reg   <= '0;
      alert_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mask_reg   <= mask_next;
      win_reg    <= win_next;
      strike_reg <= strike_next;
      hold_reg   <= hold_next;
      alert_reg  <= alert_next;
    end
  end

  // Registered control outputs, decoded from the state being entered so
  // they line up with the state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wd_kick_reg    <= 1'b0;
      wd_reset_n_reg <= 1'b0;
      sys_rst_reg    <= 1'b0;
    end else begin
      wd_kick_reg    <= (state_next == ST_KICK);
      wd_reset_n_reg <= !((state_next == ST_ALERT) || (state_next == ST_HOLD_RST));
      sys_rst_reg    <= (state_next == ST_HOLD_RST);
    end
  end

  assign wd_kick    = wd_kick_reg;
  assign wd_reset_n = wd_reset_n_reg;
  assign sys_rst    = sys_rst_reg;
  assign alert      = alert_reg;

`ifdef WDT_SUPERVISOR_STATUS_EN
  logic [NCLIENT-1:0] missing_reg;

  // Snapshot of the clients that had not checked in when the timeout hit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      missing_reg <= '0;
    end else if (take_timeout) begin
      missing_reg <= ~mask_reg;
    end
  end

  assign missing    = missing_reg;
  assign strike_cnt = strike_reg;
`else
  assign missing    = '0;
  assign strike_cnt = 3'd0;
`endif

endmodule

// File: tb/tb_wdt_supervisor.sv
// Self-checking bench for wdt_supervisor: a behavioural model of the
// supervisor rules is advanced every clock and compared against all outputs,
// plus directed scenarios with hand-computed expectations.
module tb_wdt_supervisor;
  localparam int NC  = 4;
  localparam int WIN = 10;
  localparam int STR = 2;
  localparam int HLD = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NC-1:0] checkin;
  logic          wd_timeout;
  logic          wd_kick;
  logic          wd_reset_n;
  logic          alert;
  logic          sys_rst;
  logic [NC-1:0] missing;
  logic [2:0]    strike_cnt;

  always #5 clk = ~clk;

  wdt_supervisor #(
    .NCLIENT (NC),
    .WIN_OPEN(WIN),
    .STRIKES (STR),
    .HOLD    (HLD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .checkin   (checkin),
    .wd_timeout(wd_timeout),
    .wd_kick   (wd_kick),
    .wd_reset_n(wd_reset_n),
    .alert     (alert),
    .sys_rst   (sys_rst),
    .missing   (missing),
    .strike_cnt(strike_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: flags and a countdown instead of a state register.
  bit          m_rn;          // reset_n seen at the last edge
  bit [NC-1:0] m_mask;        // clients heard from this round
  int          m_elapsed;     // cycles since last kick/alert, saturating
  bit          m_all_in;      // every client has reported this round
  bit          m_kick;        // kick pulse being issued this cycle
  bit          m_alerting;    // one-cycle re-arm after a timeout
  int          m_hold_left;   // remaining system-reset cycles
  int          m_strikes;
  bit          m_alert;
  bit [NC-1:0] m_missing;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v + 1 > WIN) ? WIN : v + 1;
  endfunction

  task automatic model_edge(input bit rn, input bit [NC-1:0] ci, input bit to);
    bit [NC-1:0] merged;
    m_rn = rn;
    if (!rn) begin
      m_mask = '0; m_elapsed = 0; m_all_in = 0; m_kick = 0; m_alerting = 0;
      m_hold_left = 0; m_strikes = 0; m_alert = 0; m_missing = '0;
    end else if (m_alerting) begin
      m_alerting = 0; m_mask = '0; m_elapsed = 0; m_all_in = 0;
      if (m_strikes == STR) m_hold_left = HLD;
    end else if (m_hold_left > 0) begin
      m_hold_left--;
      m_elapsed = sat_inc(m_elapsed);
      if (m_hold_left == 0) m_strikes = 0;
    end else if (to) begin
      m_missing  = ~m_mask;
      m_strikes++;
      m_alert    = 1;
      m_alerting = 1;
      m_elapsed  = m_kick ? 0 : sat_inc(m_elapsed);
      m_kick     = 0;
    end else if (m_kick) begin
      m_kick = 0; m_mask = ci; m_elapsed = 0; m_all_in = 0;
    end else begin
      merged = m_mask | ci;
      if (m_all_in && m_elapsed >= WIN) m_kick = 1;
      if (!m_all_in && merged == {NC{1'b1}}) m_all_in = 1;
      m_mask = merged;
      m_elapsed = sat_inc(m_elapsed);
    end
  endtask

  function automatic int exp_missing();
`ifdef WDT_SUPERVISOR_STATUS_EN
    return int'(m_missing);
`else
    return 0;
`endif
  endfunction

  function automatic int exp_strikes();
`ifdef WDT_SUPERVISOR_STATUS_EN
    return m_strikes;
`else
    return 0;
`endif
  endfunction

  // One clock: drive inputs, advance the model, compare every output.
  task automatic step(input bit rn, input bit [NC-1:0] ci, input bit to);
    reset_n = rn; checkin = ci; wd_timeout = to;
    @(posedge clk);
    model_edge(rn, ci, to);
    @(negedge clk);
    check("wd_kick",    int'(wd_kick),    int'(m_kick));
    check("wd_reset_n", int'(wd_reset_n), int'(m_rn && !m_alerting && m_hold_left == 0));
    check("sys_rst",    int'(sys_rst),    int'(m_hold_left > 0));
    check("alert",      int'(alert),      int'(m_alert));
    check("missing",    int'(missing),    exp_missing());
    check("strike_cnt", int'(strike_cnt), exp_strikes());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got timeout expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int first_kick;
    int n_kick;
    int n_hi;
    bit seen;
    bit [NC-1:0] ci;
    bit rn;
    bit to;
`ifdef WDT_SUPERVISOR_STATUS_EN
    localparam bit STATUS = 1'b1;
`else
    localparam bit STATUS = 1'b0;
`endif

    reset_n = 1'b0; checkin = '0; wd_timeout = 1'b0;
    repeat (3) step(0, '0, 0);
    check("rst_wd_kick",    int'(wd_kick),    0);
    check("rst_wd_reset_n", int'(wd_reset_n), 0);
    check("rst_alert",      int'(alert),      0);
    check("rst_sys_rst",    int'(sys_rst),    0);
    check("rst_missing",    int'(missing),    0);
    check("rst_strike_cnt", int'(strike_cnt), 0);

    // All clients check in on cycle 2: exactly one kick, on cycle 11.
    first_kick = -1; n_kick = 0;
    for (int c = 0; c < 16; c++) begin
      step(1, (c == 2) ? 4'hF : 4'h0, 0);
      if (wd_kick) begin
        n_kick++;
        if (first_kick < 0) first_kick = c + 1;
      end
    end
    check("kick_cycle", first_kick, 11);
    check("kick_count", n_kick, 1);

    // Client 2 silent, then a timeout.
    repeat (2) step(0, '0, 0);
    step(1, 4'b1011, 0);
    step(1, '0, 0);
    step(1, '0, 0);
    step(1, '0, 1);
    check("t1_alert",      int'(alert),      1);
    check("t1_missing",    int'(missing),    STATUS ? 4 : 0);
    check("t1_strike_cnt", int'(strike_cnt), STATUS ? 1 : 0);
    check("t1_wd_reset_n", int'(wd_reset_n), 0);
    step(1, '0, 0);
    check("t1_rearm_done", int'(wd_reset_n), 1);
    check("t1_no_sys_rst", int'(sys_rst),    0);

    // Second timeout escalates to an 8-cycle system reset.
    step(1, '0, 1);
    n_hi = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, '0, 0);
      if (sys_rst) n_hi++;
    end
    check("esc_sys_rst_len", n_hi, 8);
    check("esc_strike_clr",  int'(strike_cnt), 0);
    check("esc_alert_kept",  int'(alert),      1);
    check("esc_missing",     int'(missing),    STATUS ? 15 : 0);
    check("esc_wd_reset_n",  int'(wd_reset_n), 1);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step(1, 4'hF, 0);
      if (wd_kick) seen = 1;
    end
    check("esc_back_to_collect_kick", int'(seen), 1);

    // Timeout in the same cycle as the final checkin: no kick.
    repeat (2) step(0, '0, 0);
    step(1, 4'b0111, 0);
    repeat (3) step(1, '0, 0);
    step(1, 4'b1000, 1);
    check("race_alert",      int'(alert),      1);
    check("race_missing",    int'(missing),    STATUS ? 8 : 0);
    check("race_wd_reset_n", int'(wd_reset_n), 0);
    n_kick = 0;
    for (int i = 0; i < 15; i++) begin
      step(1, '0, 0);
      if (wd_kick) n_kick++;
    end
    check("race_no_kick", n_kick, 0);

    // Reset asserted on the third HOLD_RST cycle.
    repeat (2) step(0, '0, 0);
    step(1, '0, 1);
    step(1, '0, 0);
    step(1, '0, 1);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1, '0, 0);
      if (sys_rst) seen = 1;
    end
    check("hold_entered", int'(seen), 1);
    step(1, '0, 0);
    step(1, '0, 0);
    check("hold_before_reset", int'(sys_rst), 1);
    step(0, '0, 0);
    check("hold_abort_sys_rst", int'(sys_rst), 0);
    check("hold_abort_alert",   int'(alert),   0);

    // Randomized traffic against the model.
    step(0, '0, 0);
    for (int i = 0; i < 4000; i++) begin
      rn = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) ci = 4'hF;
      else ci = 4'($urandom & $urandom);
      to = ($urandom_range(0, 49) == 0);
      step(rn, ci, to);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
